// File: rtl/fifo_stage_pkg.sv
// ----------------------------------------------------------------------------
// fifo_stage_pkg
// Shared types for the stages that sit on the pop side of the common-cells
// FIFO. The spill-buffer state encoding lives here so that later FIFO-side
// stages can reuse it.
// ----------------------------------------------------------------------------
package fifo_stage_pkg;

    // Number of words held by a two-entry spill stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no words held
        ONE   = 2'd1,   // slot A valid
        TWO   = 2'd2    // slot A and slot B valid, B younger than A
    } spill_state_e;

endpackage : fifo_stage_pkg

// File: rtl/fifo_pop_spill.sv
// ----------------------------------------------------------------------------
// fifo_pop_spill
// Pop-side output stage for the common-cells FIFO. Drains the FIFO through
// its empty/pop/data interface and presents the words as a registered
// valid/ready stream. A two-entry spill buffer keeps full throughput while
// removing any combinational path from ready_i to fifo_pop_o or data_o.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous reset, active low
//   flush_i       synchronous flush, driven together with the FIFO flush
//   fifo_empty_i  FIFO empty flag
//   fifo_data_i   FIFO head data, valid while fifo_empty_i = 0
//   fifo_pop_o    pop request to the FIFO
//   valid_o       output word valid
//   ready_i       consumer accepts the output word
//   data_o        output word (register slot A)
//   occupancy_o   number of words held: 0, 1 or 2
// ----------------------------------------------------------------------------
module fifo_pop_spill
    import fifo_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter type         dtype      = logic [DATA_WIDTH-1:0]
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       fifo_empty_i,
    input  dtype       fifo_data_i,
    output logic       fifo_pop_o,
    output logic       valid_o,
    input  logic       ready_i,
    output dtype       data_o,
    output logic [1:0] occupancy_o
);

    spill_state_e state_q, state_d;
    dtype         slot_a_q, slot_b_q;

    // Write enables for the two payload registers; slot A loads either the
    // FIFO head or the younger word waiting in slot B.
    logic a_en, a_from_b, b_en;
    logic push, pop_out;

    // ------------------------------------------------------------------
    // Output logic: depends on registered state plus the FIFO flags only,
    // never on ready_i.
    // ------------------------------------------------------------------
    always_comb begin
        valid_o     = (state_q != EMPTY);
        occupancy_o = {state_q == TWO, state_q == ONE};
        fifo_pop_o  = ~fifo_empty_i & ~flush_i & (state_q != TWO);
    end

    assign data_o  = slot_a_q;
    assign push    = fifo_pop_o;
    assign pop_out = valid_o & ready_i;

    // ------------------------------------------------------------------
    // Next-state and data-move logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        a_en     = 1'b0;
        a_from_b = 1'b0;
        b_en     = 1'b0;

        if (flush_i) begin
            // Held words are dropped; slot contents are left as they are.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        a_en    = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop_out) begin
                        a_en = 1'b1;            // replace the departing word
                    end else if (push) begin
                        state_d = TWO;
                        b_en    = 1'b1;         // consumer stalled: spill
                    end else if (pop_out) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // push is impossible here: fifo_pop_o is gated by TWO.
                    if (pop_out) begin
                        state_d  = ONE;
                        a_en     = 1'b1;
                        a_from_b = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Payload registers, written only when enabled so they can be gated.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the payload slots are reset as well, so data_o is a known
        // zero out of reset rather than whatever the flops power up with.
        if (!rst_ni) begin
            slot_a_q <= '0;
            slot_b_q <= '0;
        end else begin
            if (a_en) begin
                slot_a_q <= a_from_b ? slot_b_q : fifo_data_i;
            end
            if (b_en) begin
                slot_b_q <= fifo_data_i;
            end
        end
    end

`ifndef SYNTHESIS
    // Never pop an empty FIFO.
    a_no_pop_empty : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(fifo_pop_o && fifo_empty_i)
    );

    // A stalled output word must not change.
    a_hold_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i) |=> $stable(data_o)
    );
`endif

endmodule : fifo_pop_spill
